// File: rtl/ac_exec_seq.sv
`timescale 1ns/1ps
// ac_exec_seq: AC/DR/E execution sequencer (optional INDIRECT_EN adds the IND operand-address read).
// Latency: reg-ref done at accept+2, direct mem-ref +3, indirect +4, plus one per memory wait cycle.
// Backpressure: instr_ready only in IDLE; mem_req is held until mem_rvalid.
module ac_exec_seq #(
    parameter int          ADDR_W = 12,
    parameter logic [15:0] AC_RST = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       ir,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic [3:0]        alu_code,
    output logic              alu_ei,
    input  logic [15:0]       alu_data,
    input  logic              alu_eo,
    output logic [15:0]       ac,
    output logic [15:0]       dr,
    output logic              e,
    output logic              done,
    output logic              skip,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
`ifdef INDIRECT_EN
        S_IND   = 3'd1,
`endif
        S_FETCH = 3'd2,
        S_EXEC  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP, OP_AND, OP_ADD, OP_LDA, OP_CLA, OP_CLE, OP_CMA, OP_CME,
        OP_CIR, OP_CIL, OP_INC, OP_SPA, OP_SNA, OP_SZA, OP_SZE
    } op_t;

    state_t            state, state_nxt;
    op_t               op;
    logic [2:0]        opc_q;
    logic [10:0]       rr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       ac_q, dr_q;
    logic              e_q, skip_q, err_q;
    logic [16:0]       add_sum;
    logic              accept, mem_in, rr_in;

    assign accept  = instr_valid && instr_ready;
    assign mem_in  = (ir[14:12] == 3'b000) || (ir[14:12] == 3'b001) || (ir[14:12] == 3'b010);
    assign rr_in   = (ir[14:12] == 3'b111) && !ir[15];
    assign add_sum = {1'b0, ac_q} + {1'b0, dr_q};

    // Register-ref: only the highest set bit of ir[11:1] (rr_q[10] = bit 11) executes.
    always_comb begin
        op = OP_NOP;
        case (opc_q)
            3'b000: op = OP_AND;
            3'b001: op = OP_ADD;
            3'b010: op = OP_LDA;
            3'b111: begin
                if      (rr_q[10]) op = OP_CLA;
                else if (rr_q[9])  op = OP_CLE;
                else if (rr_q[8])  op = OP_CMA;
                else if (rr_q[7])  op = OP_CME;
                else if (rr_q[6])  op = OP_CIR;
                else if (rr_q[5])  op = OP_CIL;
                else if (rr_q[4])  op = OP_INC;
                else if (rr_q[3])  op = OP_SPA;
                else if (rr_q[2])  op = OP_SNA;
                else if (rr_q[1])  op = OP_SZA;
                else if (rr_q[0])  op = OP_SZE;
                else               op = OP_NOP;
            end
            default: op = OP_NOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (mem_in) begin
`ifdef INDIRECT_EN
                        state_nxt = ir[15] ? S_IND : S_FETCH;
`else
                        state_nxt = S_FETCH;
`endif
                    end else if (rr_in) begin
                        state_nxt = S_EXEC;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
`ifdef INDIRECT_EN
            S_IND:   if (mem_rvalid) state_nxt = S_FETCH;
`endif
            S_FETCH: if (mem_rvalid) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == S_IDLE);
        mem_req     = (state == S_FETCH);
`ifdef INDIRECT_EN
        mem_req     = mem_req || (state == S_IND);
`endif
        mem_addr    = addr_q;
        done        = (state == S_DONE);
        skip        = done && skip_q;
        err         = done && err_q;
        alu_code    = 4'b1111;
        if (state == S_EXEC) begin
            case (op)
                OP_ADD:  alu_code = 4'b0000;
                OP_AND:  alu_code = 4'b0001;
                OP_CMA:  alu_code = 4'b0010;
                OP_CIR:  alu_code = 4'b0011;
                OP_CIL:  alu_code = 4'b0100;
                OP_CLA:  alu_code = 4'b0101;
                default: alu_code = 4'b1111;
            endcase
        end
    end

    // Skip tests read ac_q/e_q before this cycle's update lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q  <= 3'b000;
            rr_q   <= '0;
            addr_q <= '0;
            ac_q   <= AC_RST;
            dr_q   <= 16'h0000;
            e_q    <= 1'b0;
            skip_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        opc_q  <= ir[14:12];
                        rr_q   <= ir[11:1];
                        addr_q <= ir[ADDR_W-1:0];
                        skip_q <= 1'b0;
                        err_q  <= !(mem_in || rr_in);
                    end
                end
`ifdef INDIRECT_EN
                S_IND:   if (mem_rvalid) addr_q <= mem_rdata[ADDR_W-1:0];
`endif
                S_FETCH: if (mem_rvalid) dr_q <= mem_rdata;
                S_EXEC: begin
                    case (op)
                        OP_AND, OP_CLA, OP_CMA: ac_q <= alu_data;
                        OP_ADD: begin
                            ac_q <= alu_data;
                            e_q  <= add_sum[16];
                        end
                        OP_LDA: ac_q <= dr_q;
                        OP_CLE: e_q  <= 1'b0;
                        OP_CME: e_q  <= ~e_q;
                        OP_CIR, OP_CIL: begin
                            ac_q <= alu_data;
                            e_q  <= alu_eo;
                        end
                        OP_INC: ac_q   <= ac_q + 16'd1;
                        OP_SPA: skip_q <= ~ac_q[15];
                        OP_SNA: skip_q <= ac_q[15];
                        OP_SZA: skip_q <= (ac_q == 16'h0000);
                        OP_SZE: skip_q <= ~e_q;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign ac     = ac_q;
    assign dr     = dr_q;
    assign e      = e_q;
    assign alu_ei = e_q;

endmodule

// File: tb/tb_ac_exec_seq.sv
`timescale 1ns/1ps
// Bench for ac_exec_seq: ALU and wait-state memory models around the DUT, vector table plus
// hand-written reset/ignore sequences; completions are scored against a queue of expectations.
module tb_ac_exec_seq;

    typedef struct {
        int          id;
        logic [15:0] ir;
        logic [15:0] exp_ac;
        logic        exp_e;
        logic        exp_skip;
        logic        exp_err;
        int          exp_lat;
        logic [3:0]  exp_code;
        int          exp_reads;
        logic [11:0] exp_addr;
        int          wait_n;
    } vec_t;

    logic        clk, rst_n, instr_valid, instr_ready;
    logic [15:0] ir, mem_rdata, alu_data, ac, dr;
    logic        mem_req, mem_rvalid, alu_ei, alu_eo, e, done, skip, err;
    logic [11:0] mem_addr;
    logic [3:0]  alu_code;

    logic [15:0] mem [0:4095];
    int          wait_n, wcnt, cyc, ndone, checks, errors;
    int          acc_cyc, nreads;
    logic [3:0]  seen_code;
    logic [11:0] last_addr;
    vec_t        tbl[$];
    vec_t        sbq[$];
    vec_t        cur;

    ac_exec_seq dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .ir(ir), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .alu_code(alu_code), .alu_ei(alu_ei), .alu_data(alu_data),
        .alu_eo(alu_eo), .ac(ac), .dr(dr), .e(e), .done(done), .skip(skip), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU (external to the DUT).
    always_comb begin
        alu_data = 16'h0000;
        alu_eo   = 1'b0;
        case (alu_code)
            4'b0000: alu_data = ac + dr;
            4'b0001: alu_data = ac & dr;
            4'b0010: alu_data = ~ac;
            4'b0011: begin alu_data = {alu_ei, ac[15:1]}; alu_eo = ac[0];  end
            4'b0100: begin alu_data = {ac[14:0], alu_ei}; alu_eo = ac[15]; end
            4'b0101: alu_data = 16'h0000;
            default: ;
        endcase
    end

    // Memory answers after wait_n request cycles; zero waits answers in the first req cycle.
    assign mem_rdata  = mem[mem_addr];
    assign mem_rvalid = mem_req && (wcnt >= wait_n);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      wcnt <= 0;
        else if (mem_req && !mem_rvalid) wcnt <= wcnt + 1;
        else                             wcnt <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (instr_valid && instr_ready) begin
            acc_cyc   = cyc;
            nreads    = 0;
            seen_code = 4'hF;
        end
        if (mem_req && mem_rvalid) begin
            nreads++;
            last_addr = mem_addr;
        end
        if (alu_code != 4'hF) seen_code = alu_code;
        if (done) begin
            ndone++;
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                cur = sbq.pop_front();
                chk($sformatf("v%0d latency", cur.id), cyc - acc_cyc, cur.exp_lat);
                chk($sformatf("v%0d ac", cur.id), ac, cur.exp_ac);
                chk($sformatf("v%0d e", cur.id), e, cur.exp_e);
                chk($sformatf("v%0d skip", cur.id), skip, cur.exp_skip);
                chk($sformatf("v%0d err", cur.id), err, cur.exp_err);
                chk($sformatf("v%0d alu_code", cur.id), seen_code, cur.exp_code);
                chk($sformatf("v%0d reads", cur.id), nreads, cur.exp_reads);
                if (cur.exp_reads > 0)
                    chk($sformatf("v%0d mem_addr", cur.id), last_addr, cur.exp_addr);
            end
        end
    end

    function automatic vec_t mk(input logic [15:0] i, input logic [15:0] a, input logic ee,
                                input logic sk, input logic er, input int lat, input logic [3:0] code,
                                input int rd, input logic [11:0] ad, input int wt);
        vec_t v;
        v.id = tbl.size(); v.ir = i; v.exp_ac = a; v.exp_e = ee; v.exp_skip = sk; v.exp_err = er;
        v.exp_lat = lat; v.exp_code = code; v.exp_reads = rd; v.exp_addr = ad; v.wait_n = wt;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int prev, guard;
        wait_n = v.wait_n;
        @(posedge clk); #1;
        prev = ndone;
        sbq.push_back(v);
        ir = v.ir;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        guard = 0;
        while (ndone == prev && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        if (ndone == prev) begin
            chk($sformatf("v%0d done_timeout", v.id), 32'd0, 32'd1);
            sbq.delete();
        end
    endtask

    initial begin
        int prev;
        vec_t v;
        checks = 0; errors = 0; cyc = 0; ndone = 0; acc_cyc = 0; nreads = 0;
        seen_code = 4'hF; last_addr = '0;
        instr_valid = 1'b0; ir = 16'h0000; wait_n = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h010] = 16'hFFFF; mem[12'h011] = 16'h1234; mem[12'h012] = 16'h0001;
        mem[12'h013] = 16'h8001; mem[12'h014] = 16'h0FF0; mem[12'h016] = 16'h8000;
        mem[12'h020] = 16'h0030; mem[12'h030] = 16'h00F0;

        //           ir        ac       e  sk er lat code rd addr    wait
        tbl.push_back(mk(16'h2011, 16'h1234, 0, 0, 0, 3, 4'hF, 1, 12'h011, 0)); // LDA
        tbl.push_back(mk(16'h7800, 16'h0000, 0, 0, 0, 2, 4'h5, 0, 12'h000, 0)); // CLA
        tbl.push_back(mk(16'h2012, 16'h0001, 0, 0, 0, 3, 4'hF, 1, 12'h012, 0));
        tbl.push_back(mk(16'h1010, 16'h0000, 1, 0, 0, 3, 4'h0, 1, 12'h010, 0)); // ADD carry
        tbl.push_back(mk(16'h2013, 16'h8001, 1, 0, 0, 3, 4'hF, 1, 12'h013, 0));
        tbl.push_back(mk(16'h7400, 16'h8001, 0, 0, 0, 2, 4'hF, 0, 12'h000, 0)); // CLE
        tbl.push_back(mk(16'h7080, 16'h4000, 1, 0, 0, 2, 4'h3, 0, 12'h000, 0)); // CIR
        tbl.push_back(mk(16'h7400, 16'h4000, 0, 0, 0, 2, 4'hF, 0, 12'h000, 0));
        tbl.push_back(mk(16'h7040, 16'h8000, 0, 0, 0, 2, 4'h4, 0, 12'h000, 0)); // CIL
        tbl.push_back(mk(16'h7020, 16'h8001, 0, 0, 0, 2, 4'hF, 0, 12'h000, 0)); // INC
        tbl.push_back(mk(16'h7008, 16'h8001, 0, 1, 0, 2, 4'hF, 0, 12'h000, 0)); // SNA
        tbl.push_back(mk(16'h7010, 16'h8001, 0, 0, 0, 2, 4'hF, 0, 12'h000, 0)); // SPA
        tbl.push_back(mk(16'h2010, 16'hFFFF, 0, 0, 0, 4, 4'hF, 1, 12'h010, 1)); // one wait
        tbl.push_back(mk(16'h7020, 16'h0000, 0, 0, 0, 2, 4'hF, 0, 12'h000, 0)); // INC wrap
        tbl.push_back(mk(16'h7004, 16'h0000, 0, 1, 0, 2, 4'hF, 0, 12'h000, 0)); // SZA
        tbl.push_back(mk(16'h7100, 16'h0000, 1, 0, 0, 2, 4'hF, 0, 12'h000, 0)); // CME
        tbl.push_back(mk(16'h7002, 16'h0000, 1, 0, 0, 2, 4'hF, 0, 12'h000, 0)); // SZE, e=1
        tbl.push_back(mk(16'h7200, 16'hFFFF, 1, 0, 0, 2, 4'h2, 0, 12'h000, 0)); // CMA
        tbl.push_back(mk(16'h7C00, 16'h0000, 1, 0, 0, 2, 4'h5, 0, 12'h000, 0)); // CLA wins over CLE
        tbl.push_back(mk(16'h1010, 16'hFFFF, 0, 0, 0, 5, 4'h0, 1, 12'h010, 2)); // ADD no carry
        tbl.push_back(mk(16'h7000, 16'hFFFF, 0, 0, 0, 2, 4'hF, 0, 12'h000, 0)); // no-op
        tbl.push_back(mk(16'h7002, 16'hFFFF, 0, 1, 0, 2, 4'hF, 0, 12'h000, 0)); // SZE, e=0
        tbl.push_back(mk(16'h3005, 16'hFFFF, 0, 0, 1, 1, 4'hF, 0, 12'h000, 0)); // opcode 011
        tbl.push_back(mk(16'hF000, 16'hFFFF, 0, 0, 1, 1, 4'hF, 0, 12'h000, 0)); // I=1, 111
        tbl.push_back(mk(16'h5123, 16'hFFFF, 0, 0, 1, 1, 4'hF, 0, 12'h000, 0)); // opcode 101
        tbl.push_back(mk(16'h2014, 16'h0FF0, 0, 0, 0, 3, 4'hF, 1, 12'h014, 0));
`ifdef INDIRECT_EN
        tbl.push_back(mk(16'h8020, 16'h00F0, 0, 0, 0, 4, 4'h1, 2, 12'h030, 0)); // AND indirect
        tbl.push_back(mk(16'h2014, 16'h0FF0, 0, 0, 0, 3, 4'hF, 1, 12'h014, 0));
        tbl.push_back(mk(16'h8020, 16'h00F0, 0, 0, 0, 8, 4'h1, 2, 12'h030, 2));
`else
        tbl.push_back(mk(16'h8020, 16'h0030, 0, 0, 0, 3, 4'h1, 1, 12'h020, 0)); // I ignored
        tbl.push_back(mk(16'h2014, 16'h0FF0, 0, 0, 0, 3, 4'hF, 1, 12'h014, 0));
        tbl.push_back(mk(16'h8020, 16'h0030, 0, 0, 0, 5, 4'h1, 1, 12'h020, 2));
`endif
        tbl.push_back(mk(16'h2016, 16'h8000, 0, 0, 0, 3, 4'hF, 1, 12'h016, 0));
        tbl.push_back(mk(16'h7010, 16'h8000, 0, 0, 0, 2, 4'hF, 0, 12'h000, 0)); // SPA, neg
        tbl.push_back(mk(16'h7004, 16'h8000, 0, 0, 0, 2, 4'hF, 0, 12'h000, 0)); // SZA, nonzero
        tbl.push_back(mk(16'h0012, 16'h0000, 0, 0, 0, 3, 4'h1, 1, 12'h012, 0)); // AND direct
        tbl.push_back(mk(16'h2011, 16'h1234, 0, 0, 0, 3, 4'hF, 1, 12'h011, 0));

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        chk("rst ac", ac, 16'h0000);
        chk("rst dr", dr, 16'h0000);
        chk("rst e", e, 1'b0);
        chk("rst mem_req", mem_req, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst skip", skip, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst alu_code", alu_code, 4'hF);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("idle instr_ready", instr_ready, 1'b1);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Abort a long FETCH by reset; a second instruction offered meanwhile must be ignored.
        wait_n = 20;
        prev = ndone;
        @(posedge clk); #1;
        ir = 16'h2011; instr_valid = 1'b1;
        @(posedge clk); #1;
        ir = 16'h7800;
        @(negedge clk);
        chk("busy instr_ready", instr_ready, 1'b0);
        chk("fetch mem_req", mem_req, 1'b1);
        chk("fetch mem_addr", mem_addr, 12'h011);
        @(negedge clk);
        chk("fetch dr held", dr, 16'h1234);
        #1 rst_n = 1'b0;
        #1;
        chk("abort mem_req", mem_req, 1'b0);
        chk("abort ac", ac, 16'h0000);
        chk("abort dr", dr, 16'h0000);
        chk("abort done", done, 1'b0);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort no done", ndone, prev);

        v = mk(16'h2013, 16'h8001, 0, 0, 0, 3, 4'hF, 1, 12'h013, 0);
        v.id = 100;
        run_vec(v);
        v = mk(16'h7080, 16'h4000, 1, 0, 0, 2, 4'h3, 0, 12'h000, 0);
        v.id = 101;
        run_vec(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
